// File: rtl/wb_ram_b3_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_ram_b3_if
// Description : Wishbone B3 bus bundle between one master and the RAM responder.
//               Carries the classic handshake plus cti/bte burst tags.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_ram_b3_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  localparam int SEL_WIDTH = DATA_WIDTH >> 3;

  logic [ADDR_WIDTH-1:0] wb_adr_i;
  logic [DATA_WIDTH-1:0] wb_dat_i;
  logic                  wb_cyc_i;
  logic                  wb_stb_i;
  logic [SEL_WIDTH-1:0]  wb_sel_i;
  logic                  wb_we_i;
  logic [2:0]            wb_cti_i;
  logic [1:0]            wb_bte_i;
  logic [DATA_WIDTH-1:0] wb_dat_o;
  logic                  wb_ack_o;
  logic                  wb_err_o;
  logic                  wb_rty_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_cyc_i, wb_stb_i, wb_sel_i, wb_we_i,
           wb_cti_i, wb_bte_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_cyc_i, wb_stb_i, wb_sel_i, wb_we_i,
           wb_cti_i, wb_bte_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );
endinterface
`default_nettype wire

// File: rtl/wb_ram_b3.sv
`default_nettype none
// ============================================================================
// Module      : wb_ram_b3
// Description : Wishbone B3 responder with on-chip RAM. Serves classic single
//               accesses; with WB_RAM_B3_BURST_EN defined it also serves
//               registered-feedback incrementing/wrapping bursts (cti/bte).
//               Word accesses beyond MEM_WORDS are answered with a bus error.
//               Optional feature macro: WB_RAM_B3_BURST_EN
// Revision    : 1.0 - initial release
// ============================================================================
module wb_ram_b3 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_WORDS  = 1024
) (
  input  wire logic  clk_i,
  input  wire logic  rst_i,
  wb_ram_b3_if.slave wb
);

  localparam int SEL_WIDTH  = DATA_WIDTH >> 3;
  localparam int LANE_SHIFT = (SEL_WIDTH > 1) ? $clog2(SEL_WIDTH) : 0;
  localparam int IDX_W      = ADDR_WIDTH - LANE_SHIFT;
  localparam int MEM_AW     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  // Word count expressed at word-index width for range comparisons.
  localparam logic [IDX_W-1:0] MEM_LIMIT = IDX_W'(MEM_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  // Storage; contents are deliberately not cleared by reset.
  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  state_t                state;
  state_t                state_n;
  logic [IDX_W-1:0]      beat_addr;
  logic [IDX_W-1:0]      beat_addr_n;
  logic [DATA_WIDTH-1:0] dat_r;
  logic                  ack_r;
  logic                  ack_n;
  logic                  err_r;
  logic                  err_n;
  logic                  load_dat;
  logic [MEM_AW-1:0]     rd_idx;
  logic                  mem_we;

  logic                  req;
  logic [IDX_W-1:0]      adr_idx;
  logic [IDX_W-1:0]      next_addr;
  logic                  next_in_range;
  logic                  burst_go;

  assign req     = wb.wb_cyc_i & wb.wb_stb_i;
  assign adr_idx = wb.wb_adr_i[ADDR_WIDTH-1:LANE_SHIFT];

  // Byte-offset bits below the word index carry no meaning for a word RAM.
  if (LANE_SHIFT > 0) begin : g_lane_bits
    logic unused_lane_bits;
    assign unused_lane_bits = ^wb.wb_adr_i[LANE_SHIFT-1:0];
  end

`ifdef WB_RAM_B3_BURST_EN
  logic [IDX_W-1:0] wrap_mask;

  // Wrap mask picks the low beat-address bits that advance; the rest hold.
  always_comb begin
    case (wb.wb_bte_i)
      2'b01:   wrap_mask = IDX_W'(3);
      2'b10:   wrap_mask = IDX_W'(7);
      2'b11:   wrap_mask = IDX_W'(15);
      default: wrap_mask = '1;
    endcase
  end

  assign next_addr = (beat_addr & ~wrap_mask) | ((beat_addr + IDX_W'(1)) & wrap_mask);
  assign burst_go  = req & (wb.wb_cti_i == 3'b010);
`else
  // Without burst support every beat is a classic access: cti/bte are ignored.
  logic unused_burst_ctl;
  assign unused_burst_ctl = ^{wb.wb_cti_i, wb.wb_bte_i};
  assign next_addr        = beat_addr;
  assign burst_go         = 1'b0;
`endif

  assign next_in_range = (next_addr < MEM_LIMIT);

  // Next-state, next-register values and the RAM write strobe of the FSM.
  always_comb begin
    state_n     = state;
    beat_addr_n = beat_addr;
    ack_n       = ack_r;
    err_n       = err_r;
    load_dat    = 1'b0;
    rd_idx      = beat_addr[MEM_AW-1:0];
    mem_we      = 1'b0;

    if (!wb.wb_cyc_i) begin
      // Losing the cycle abandons whatever was in flight.
      state_n = ST_IDLE;
      ack_n   = 1'b0;
      err_n   = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          ack_n = 1'b0;
          err_n = 1'b0;
          if (req) begin
            if (adr_idx >= MEM_LIMIT) begin
              err_n   = 1'b1;
              state_n = ST_ERR;
            end else begin
              beat_addr_n = adr_idx;
              rd_idx      = adr_idx[MEM_AW-1:0];
              load_dat    = 1'b1;
              ack_n       = 1'b1;
              state_n     = ST_ACK;
            end
          end
        end

        ST_ACK: begin
          // The beat being acknowledged commits its write on this edge.
          mem_we = ack_r & req & wb.wb_we_i & ~rst_i;
          if (burst_go) begin
            if (next_in_range) begin
              beat_addr_n = next_addr;
              rd_idx      = next_addr[MEM_AW-1:0];
              load_dat    = 1'b1;
              ack_n       = 1'b1;
            end else begin
              ack_n   = 1'b0;
              err_n   = 1'b1;
              state_n = ST_ERR;
            end
          end else begin
            ack_n   = 1'b0;
            state_n = ST_IDLE;
          end
        end

        ST_ERR: begin
          err_n   = 1'b0;
          state_n = ST_IDLE;
        end

        default: begin
          ack_n   = 1'b0;
          err_n   = 1'b0;
          state_n = ST_IDLE;
        end
      endcase
    end
  end

  // State, beat address, response flags and registered read data.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      beat_addr <= '0;
      dat_r     <= '0;
      ack_r     <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      state     <= state_n;
      beat_addr <= beat_addr_n;
      ack_r     <= ack_n;
      err_r     <= err_n;
      if (load_dat) begin
        dat_r <= mem[rd_idx];
      end
    end
  end

  // Byte-lane RAM write for the beat currently being acknowledged.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int i = 0; i < SEL_WIDTH; i++) begin
        if (wb.wb_sel_i[i]) begin
          mem[beat_addr[MEM_AW-1:0]][i*8 +: 8] <= wb.wb_dat_i[i*8 +: 8];
        end
      end
    end
  end

  // Responses are gated by the live request so a dropped strobe never sees
  // a stale acknowledge or error.
  assign wb.wb_ack_o = ack_r & req;
  assign wb.wb_err_o = err_r & req;
  assign wb.wb_rty_o = 1'b0;
  assign wb.wb_dat_o = dat_r;

endmodule
`default_nettype wire

// File: tb/tb_wb_ram_b3.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_ram_b3
// Description : Self-checking bench for wb_ram_b3. A bus master drives
//               classic and burst transfers; a word-level model predicts the
//               cycle of every response and the data returned.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_ram_b3;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MW = 60;

`ifdef WB_RAM_B3_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_ram_b3_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  wb_ram_b3 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_WORDS(MW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .wb    (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference RAM and per-transfer stimulus/expectation storage.
  logic [31:0] ref_mem [MW];
  logic [31:0] wdat [16];
  logic [3:0]  wsel [16];
  logic [63:0] obs_ack, obs_err, exp_ack, exp_err;
  logic [31:0] obs_dat [64];
  logic [31:0] exp_dat [64];
  bit          exp_rd  [64];
  logic        rst_ack;
  logic [31:0] rst_dat;

  // Word visited by beat i: linear counts up, wrapN cycles inside its block.
  function automatic int beat_word(int start, int i, logic [1:0] bte);
    int n, base;
    if (bte == 2'b00) return start + i;
    n    = 2 << bte;
    base = (start / n) * n;
    return base + ((start - base + i) % n);
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (sel[k]) r[8*k +: 8] = nw[8*k +: 8];
    return r;
  endfunction

  // Model: beat i answers at cycle i+1 in burst mode, 2i+1 when classic.
  task automatic predict(bit we, int start, int n, logic [1:0] bte, int abort_after);
    int lim, w, c;
    exp_ack = '0;
    exp_err = '0;
    for (int k = 0; k < 64; k++) begin exp_rd[k] = 1'b0; exp_dat[k] = '0; end
    lim = (abort_after > 0 && abort_after < n) ? abort_after : n;
    for (int i = 0; i < lim; i++) begin
      w = beat_word(start, i, bte);
      c = BURST ? i + 1 : 2 * i + 1;
      if (w >= MW) begin
        exp_err[c] = 1'b1;
        break;
      end
      exp_ack[c] = 1'b1;
      if (we) ref_mem[w] = merge(ref_mem[w], wdat[i], wsel[i]);
      else begin exp_rd[c] = 1'b1; exp_dat[c] = ref_mem[w]; end
    end
  endtask

  task automatic bus_idle();
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    bus.wb_adr_i = '0;   bus.wb_dat_i = '0;   bus.wb_sel_i = '0;
    bus.wb_cti_i = '0;   bus.wb_bte_i = '0;
  endtask

  task automatic bus_beat(bit we, int start, int n, int b, logic [1:0] bte, logic [2:0] single_cti);
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = we;
    bus.wb_adr_i = 32'(beat_word(start, b, bte)) << 2;
    bus.wb_dat_i = wdat[b];
    bus.wb_sel_i = wsel[b];
    bus.wb_cti_i = (n == 1) ? single_cti : ((b == n - 1) ? 3'b111 : 3'b010);
    bus.wb_bte_i = bte;
  endtask

  // Master: present beats, advance on ack, stop on err, optional abort
  // (mode 1 drops cyc, mode 2 pulses reset) after abort_after beats.
  task automatic run_burst(bit we, int start, int n, logic [1:0] bte, logic [2:0] single_cti,
                           int abort_after, int abort_mode);
    int b = 0;
    bit done = 1'b0;
    int horizon = 2 * n + 4;
    obs_ack = '0;
    obs_err = '0;
    rst_ack = 1'b1;
    rst_dat = '1;
    for (int k = 0; k < 64; k++) obs_dat[k] = '0;
    for (int c = 0; c < horizon; c++) begin
      if (done) bus_idle();
      else bus_beat(we, start, n, b, bte, single_cti);
      @(negedge clk);
      obs_ack[c] = bus.wb_ack_o;
      obs_err[c] = bus.wb_err_o;
      obs_dat[c] = bus.wb_dat_o;
      @(posedge clk); #1;
      if (!done) begin
        if (obs_err[c]) done = 1'b1;
        else if (obs_ack[c]) begin
          b++;
          if (b == n) done = 1'b1;
          else if (abort_mode != 0 && b == abort_after) begin
            done = 1'b1;
            if (abort_mode == 2) begin
              bus_beat(we, start, n, b, bte, single_cti);
              rst = 1'b1;
              #1;
              rst_ack = bus.wb_ack_o;
              rst_dat = bus.wb_dat_o;
              @(posedge clk); #1;
              rst = 1'b0;
            end
          end
        end
      end
    end
    bus_idle();
  endtask

  task automatic write_word(int w, logic [31:0] d);
    wdat[0] = d;
    wsel[0] = 4'hF;
    run_burst(1'b1, w, 1, 2'b00, 3'b000, 0, 0);
    predict(1'b1, w, 1, 2'b00, 0);
  endtask

  task automatic test_reset();
    bus_idle();
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    @(negedge clk);
    checks++; if (bus.wb_ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", bus.wb_ack_o); end
    checks++; if (bus.wb_err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.wb_err_o); end
    checks++; if (bus.wb_dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat: got %h want 0", bus.wb_dat_o); end
    checks++; if (bus.wb_rty_o !== 1'b0) begin errors++; $display("FAIL reset_rty: got %b want 0", bus.wb_rty_o); end
    @(posedge clk); #1;
    bus_idle();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.wb_dat_o !== 32'h0) begin errors++; $display("FAIL post_reset_dat: got %h want 0", bus.wb_dat_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_classic();
    wdat[0] = 32'hDEADBEEF; wsel[0] = 4'hF;
    run_burst(1'b1, 4, 1, 2'b00, 3'b000, 0, 0);
    predict(1'b1, 4, 1, 2'b00, 0);
    checks++; if (obs_ack !== exp_ack) begin errors++; $display("FAIL classic_wr_ack: got %h want %h", obs_ack, exp_ack); end
    checks++; if (obs_err !== exp_err) begin errors++; $display("FAIL classic_wr_err: got %h want %h", obs_err, exp_err); end
    run_burst(1'b0, 4, 1, 2'b00, 3'b000, 0, 0);
    predict(1'b0, 4, 1, 2'b00, 0);
    checks++; if (obs_ack !== 64'h2) begin errors++; $display("FAIL classic_rd_ack: got %h want %h", obs_ack, 64'h2); end
    checks++; if (obs_dat[1] !== 32'hDEADBEEF) begin errors++; $display("FAIL classic_rd_dat: got %h want deadbeef", obs_dat[1]); end
  endtask

  task automatic test_byte_lanes();
    wdat[0] = 32'h000000AA; wsel[0] = 4'b0001;
    run_burst(1'b1, 4, 1, 2'b00, 3'b000, 0, 0);
    predict(1'b1, 4, 1, 2'b00, 0);
    wdat[0] = 32'h12345678; wsel[0] = 4'b0000;
    run_burst(1'b1, 4, 1, 2'b00, 3'b000, 0, 0);
    predict(1'b1, 4, 1, 2'b00, 0);
    checks++; if (obs_ack !== exp_ack) begin errors++; $display("FAIL sel0_write_ack: got %h want %h", obs_ack, exp_ack); end
    run_burst(1'b0, 4, 1, 2'b00, 3'b000, 0, 0);
    predict(1'b0, 4, 1, 2'b00, 0);
    checks++; if (obs_dat[1] !== 32'hDEADBEAA) begin errors++; $display("FAIL byte_lane_dat: got %h want deadbeaa", obs_dat[1]); end
  endtask

  task automatic test_linear_burst();
    for (int k = 0; k < 4; k++) write_word(8 + k, 32'(k + 1));
    run_burst(1'b0, 8, 4, 2'b00, 3'b000, 0, 0);
    predict(1'b0, 8, 4, 2'b00, 0);
    checks++; if (obs_ack !== exp_ack) begin errors++; $display("FAIL linear_ack: got %h want %h", obs_ack, exp_ack); end
    for (int c = 0; c < 64; c++) if (exp_rd[c]) begin
      checks++; if (obs_dat[c] !== exp_dat[c]) begin errors++; $display("FAIL linear_dat c%0d: got %h want %h", c, obs_dat[c], exp_dat[c]); end
    end
  endtask

  task automatic test_wrap_burst();
    run_burst(1'b0, 6, 4, 2'b01, 3'b000, 0, 0);
    predict(1'b0, 6, 4, 2'b01, 0);
    checks++; if (obs_ack !== exp_ack) begin errors++; $display("FAIL wrap4_ack: got %h want %h", obs_ack, exp_ack); end
    for (int c = 0; c < 64; c++) if (exp_rd[c]) begin
      checks++; if (obs_dat[c] !== exp_dat[c]) begin errors++; $display("FAIL wrap4_dat c%0d: got %h want %h", c, obs_dat[c], exp_dat[c]); end
    end
  endtask

  task automatic test_errors();
    wdat[0] = 32'hBAD0BAD0; wsel[0] = 4'hF;
    run_burst(1'b1, MW, 1, 2'b00, 3'b000, 0, 0);
    predict(1'b1, MW, 1, 2'b00, 0);
    checks++; if (obs_err !== 64'h2) begin errors++; $display("FAIL err_edge_err: got %h want %h", obs_err, 64'h2); end
    checks++; if (obs_ack !== 64'h0) begin errors++; $display("FAIL err_edge_ack: got %h want 0", obs_ack); end
    run_burst(1'b1, 64, 1, 2'b00, 3'b000, 0, 0);
    predict(1'b1, 64, 1, 2'b00, 0);
    checks++; if (obs_err !== exp_err) begin errors++; $display("FAIL err_far_err: got %h want %h", obs_err, exp_err); end
    for (int w = 0; w < 8; w += 4) begin
      run_burst(1'b0, w, 1, 2'b00, 3'b000, 0, 0);
      predict(1'b0, w, 1, 2'b00, 0);
      checks++; if (obs_dat[1] !== exp_dat[1]) begin errors++; $display("FAIL err_no_alias w%0d: got %h want %h", w, obs_dat[1], exp_dat[1]); end
    end
    run_burst(1'b0, MW - 2, 4, 2'b00, 3'b000, 0, 0);
    predict(1'b0, MW - 2, 4, 2'b00, 0);
    checks++; if (obs_ack !== exp_ack) begin errors++; $display("FAIL burst_err_ack: got %h want %h", obs_ack, exp_ack); end
    checks++; if (obs_err !== exp_err) begin errors++; $display("FAIL burst_err_err: got %h want %h", obs_err, exp_err); end
  endtask

  task automatic test_abort();
    for (int mode = 1; mode <= 2; mode++) begin
      int base = (mode == 1) ? 20 : 24;
      for (int k = 0; k < 4; k++) begin wdat[k] = $urandom; wsel[k] = 4'hF; end
      run_burst(1'b1, base, 4, 2'b00, 3'b000, 2, mode);
      predict(1'b1, base, 4, 2'b00, 2);
      checks++; if (obs_ack !== exp_ack) begin errors++; $display("FAIL abort%0d_ack: got %h want %h", mode, obs_ack, exp_ack); end
      if (mode == 2) begin
        checks++; if (rst_ack !== 1'b0) begin errors++; $display("FAIL abort_rst_ack_now: got %b want 0", rst_ack); end
        checks++; if (rst_dat !== 32'h0) begin errors++; $display("FAIL abort_rst_dat: got %h want 0", rst_dat); end
      end
      for (int k = 0; k < 4; k++) begin
        run_burst(1'b0, base + k, 1, 2'b00, 3'b000, 0, 0);
        predict(1'b0, base + k, 1, 2'b00, 0);
        checks++; if (obs_ack !== exp_ack) begin errors++; $display("FAIL abort%0d_rd_ack w%0d: got %h want %h", mode, base + k, obs_ack, exp_ack); end
        checks++; if (obs_dat[1] !== exp_dat[1]) begin errors++; $display("FAIL abort%0d_rd_dat w%0d: got %h want %h", mode, base + k, obs_dat[1], exp_dat[1]); end
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 24; it++) begin
      bit we = 1'($urandom_range(0, 1));
      int sel_n = $urandom_range(0, 3);
      int n = (sel_n == 0) ? 1 : ((sel_n == 1) ? 4 : ((sel_n == 2) ? 8 : 16));
      logic [1:0] bte = (n == 1) ? 2'b00 : 2'($urandom_range(0, 3));
      logic [2:0] scti = $urandom_range(0, 1) ? 3'b111 : 3'b000;
      int start = $urandom_range(0, MW + 3);
      for (int k = 0; k < n; k++) begin wdat[k] = $urandom; wsel[k] = 4'($urandom_range(0, 15)); end
      run_burst(we, start, n, bte, scti, 0, 0);
      predict(we, start, n, bte, 0);
      checks++; if (obs_ack !== exp_ack) begin errors++; $display("FAIL rand%0d_ack: got %h want %h", it, obs_ack, exp_ack); end
      checks++; if (obs_err !== exp_err) begin errors++; $display("FAIL rand%0d_err: got %h want %h", it, obs_err, exp_err); end
      for (int c = 0; c < 64; c++) if (exp_rd[c]) begin
        checks++; if (obs_dat[c] !== exp_dat[c]) begin errors++; $display("FAIL rand%0d_dat c%0d: got %h want %h", it, c, obs_dat[c], exp_dat[c]); end
      end
    end
  endtask

  initial begin
    bus_idle();
    for (int k = 0; k < MW; k++) ref_mem[k] = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    for (int k = 0; k < MW; k++) write_word(k, $urandom);
    test_classic();
    test_byte_lanes();
    test_linear_burst();
    test_wrap_burst();
    test_errors();
    test_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end
endmodule
`default_nettype wire
